// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that feeds single bytes from NREQ
//                requesters into one UART transmitter, with a busy-rise
//                watchdog that raises a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ         = 4,   // number of requesters, 2..8
  parameter int BUSY_TIMEOUT = 16,  // cycles after tx_start allowed for tx_busy to rise (>= 2)
  localparam int GID_W       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GID_W-1:0]     grant_id,
  output logic                 active,
  output logic                 err
);

  localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_RISE = 2'd2,
    S_WAIT_FALL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [7:0]         req_byte [NREQ];
  logic [GID_W:0]     rr_sum;
  logic [GID_W-1:0]   rr_idx;
  logic [GID_W-1:0]   rr_winner;
  logic               rr_found;

  // Split the flat data bus into one byte per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: first requester after the last grant, wrapping at NREQ.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = grant_q;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_sum = {1'b0, grant_q} + (GID_W+1)'(k);
      if (rr_sum >= (GID_W+1)'(NREQ)) begin
        rr_sum = rr_sum - (GID_W+1)'(NREQ);
      end
      rr_idx = rr_sum[GID_W-1:0];
      if (!rr_found && req[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  // Next-state and output decode; launch pulses come straight from S_LAUNCH.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tx_start = 1'b0;
    ack      = '0;
    case (state_q)
      S_IDLE: begin
        // req is only looked at here; busy transmitter blocks any launch.
        if (!tx_busy && rr_found) begin
          grant_d = rr_winner;
          data_d  = req_byte[rr_winner];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tx_start      = 1'b1;
        ack[grant_q]  = 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (tx_busy) begin
          state_d = S_WAIT_FALL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Transmitter never acknowledged the start: flag it and move on.
          if (cnt_d == CNT_W'(BUSY_TIMEOUT-1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_FALL: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset leaves grant at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= GID_W'(NREQ-1);
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign err      = err_q;
  assign active   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 16, giving the cycles allowed after tx_start for tx_busy to rise.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  bit i high: requester i holds a byte to send.
REQ-006 req_data  input  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-007 ack  output  NREQ  one-cycle pulse on bit i: byte of requester i captured.
REQ-008 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte for the UART transmitter, registered, stable from tx_start until the next launch.
REQ-010 tx_busy  input  1  busy flag from the UART transmitter.
REQ-011 grant_id  output  clog2(NREQ)  index of the requester last granted.
REQ-012 active  output  1  high whenever the FSM is not in S_IDLE.
REQ-013 err  output  1  sticky flag: the transmitter failed to assert busy.

Function
REQ-014 The FSM SHALL have four states: S_IDLE, S_LAUNCH, S_WAIT_RISE, S_WAIT_FALL.
REQ-015 S_IDLE with any req bit high and tx_busy=0 SHALL select a winner, capture its byte into tx_data, set grant_id, and go to S_LAUNCH.
REQ-016 Arbitration SHALL be round-robin: search starts at (grant_id+1) mod NREQ and wraps, so index NREQ-1 is followed by 0.
REQ-017 S_IDLE with tx_busy=1 SHALL not launch, whatever req holds.
REQ-018 S_LAUNCH SHALL last exactly one cycle:
- tx_start=1 and ack[grant_id]=1 in that cycle only.
- Wait counter cleared.
- Next state S_WAIT_RISE.
REQ-019 Launch latency SHALL be one cycle: a req first seen in S_IDLE at edge T gives tx_start high during cycle T+1.
REQ-020 S_WAIT_RISE behaviour:
- tx_busy=1: go to S_WAIT_FALL.
- Otherwise the wait counter increments.
- Counter reaching BUSY_TIMEOUT-1 with tx_busy still 0: set err, return to S_IDLE.
REQ-021 S_WAIT_FALL SHALL return to S_IDLE on the first cycle tx_busy=0.
REQ-022 req SHALL be sampled only in S_IDLE. Changes to req or req_data in any other state SHALL have no effect.
REQ-023 A requester keeping req high after its ack SHALL be treated as a new byte. Under round-robin it is not re-granted while another requester is pending.
REQ-024 Minimum spacing between consecutive tx_start pulses SHALL be 4 cycles.
REQ-025 At most one ack bit SHALL be high in any cycle, and only together with tx_start.
REQ-026 err, once set, SHALL stay high until reset; arbitration continues while err is set.

Reset
REQ-027 rst high SHALL immediately, without waiting for clk, force:
- FSM to S_IDLE.
- ack=0, tx_start=0, tx_data=0, err=0.
- grant_id=NREQ-1, so requester 0 wins first.
- active=0, wait counter=0.
REQ-028 Reset in the middle of a transfer SHALL abandon it without further pulses. The first launch after rst falls SHALL follow REQ-015 and REQ-016.

Verification
REQ-029 After reset, req=4'b0001, data0=8'hA5, busy model rising one cycle after start and lasting 10 cycles:
- tx_start one cycle after req, tx_data=8'hA5, ack=4'b0001, grant_id=0.
- active falls the cycle after busy falls.
REQ-030 req=4'b1111 held with distinct bytes 8'h10..8'h13: four launches in order 0,1,2,3, then 0 again; ack one-hot each time.
REQ-031 tx_busy held high externally with req=4'b0010: no tx_start while busy. Launch occurs one cycle after busy drops.
REQ-032 Busy model never asserts:
- err rises BUSY_TIMEOUT cycles after tx_start and stays high.
- FSM returns to S_IDLE.
- A subsequent request still launches.
REQ-033 rst pulsed during S_WAIT_FALL:
- All outputs reset asynchronously.
- With req=4'b0100 afterwards, the next grant is to requester 2 (grant_id=2), starting from the REQ-027 reset state.
REQ-034 req_data changed during S_WAIT_FALL: tx_data unchanged until the next launch.
